// File: rtl/host_bus_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : host_bus_monitor
// Purpose  : Monitor for the S1D13700 8080-style host bus. Every bus input is
//            synchronised into the clk domain. Each completed write access,
//            and each read access when enabled, becomes a record
//            {rd_flag, a0, dat}. Records are queued in a small FIFO and sent
//            out LSB first as UART-like frames (start, DW+2 bits, stop).
// Ports    : clk       system clock
//            rst_x     asynchronous reset, active low
//            ce_x      host chip select, active low (async)
//            a0        host address bit (async)
//            wr_x      host write strobe, active low (async)
//            rd_x      host read strobe, active low (async)
//            dat       host data bus, DW bits (async)
//            en        capture enable (synchronous)
//            sout      serial frame output, idle high
//            busy      high while a frame is being shifted
//            ovf       sticky record-dropped flag
//            fifo_lvl  FIFO occupancy, 0..2**FIFO_AW
// Revision : 1.0  initial release
// ============================================================================
module host_bus_monitor #(
    parameter int DW       = 8,
    parameter int FIFO_AW  = 4,
    parameter int BAUD_DIV = 16,
    parameter int CAP_RD   = 1,
    parameter int SYNC_STG = 2
) (
    input  logic               clk,
    input  logic               rst_x,
    input  logic               ce_x,
    input  logic               a0,
    input  logic               wr_x,
    input  logic               rd_x,
    input  logic [DW-1:0]      dat,
    input  logic               en,
    output logic               sout,
    output logic               busy,
    output logic               ovf,
    output logic [FIFO_AW:0]   fifo_lvl
);

    // Synchronised bus layout: {ce, a0, wr, rd, dat}
    localparam int c_BW    = DW + 4;
    localparam int c_RW    = DW + 2;
    localparam int c_CE    = DW + 3;
    localparam int c_A0    = DW + 2;
    localparam int c_WR    = DW + 1;
    localparam int c_RD    = DW;
    localparam int c_DEPTH = 2 ** FIFO_AW;
    localparam int c_BCW   = $clog2(BAUD_DIV);
    localparam int c_BITW  = $clog2(DW + 2);

    // Strobes and chip select idle high; resetting the synchronisers to the
    // idle level keeps reset release from looking like a rising strobe.
    localparam logic [c_BW-1:0]    c_BUS_IDLE  = {1'b1, 1'b0, 1'b1, 1'b1, {DW{1'b0}}};
    localparam logic [c_BCW-1:0]   c_BAUD_LAST = c_BCW'(BAUD_DIV - 1);
    localparam logic [c_BITW-1:0]  c_LAST_BIT  = c_BITW'(DW + 1);
    localparam logic [FIFO_AW:0]   c_FULL      = (FIFO_AW + 1)'(c_DEPTH);
    localparam bit                 c_CAP_RD    = (CAP_RD != 0);

    // ------------------------------------------------------------------------
    // Input synchronisers plus one "previous sample" stage
    // ------------------------------------------------------------------------
    logic [SYNC_STG-1:0][c_BW-1:0] r_sync;
    logic [c_BW-1:0]               r_bus_p;
    logic [c_BW-1:0]               w_bus_in;

    assign w_bus_in = {ce_x, a0, wr_x, rd_x, dat};

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_sync  <= {SYNC_STG{c_BUS_IDLE}};
            r_bus_p <= c_BUS_IDLE;
        end else begin
            r_sync  <= {r_sync[SYNC_STG-2:0], w_bus_in};
            r_bus_p <= r_sync[SYNC_STG-1];
        end
    end

    // ------------------------------------------------------------------------
    // Event detection: strobe rising while chip select was low. Data and a0
    // come from the previous stage, i.e. the last sample with the strobe low.
    // A simultaneous write wins over a read.
    // ------------------------------------------------------------------------
    logic w_wr_evt;
    logic w_rd_evt;
    logic r_push;
    logic [c_RW-1:0] r_push_rec;

    assign w_wr_evt = en & ~r_bus_p[c_WR] & r_sync[SYNC_STG-1][c_WR] & ~r_bus_p[c_CE];
    assign w_rd_evt = c_CAP_RD & en & ~r_bus_p[c_RD] & r_sync[SYNC_STG-1][c_RD]
                      & ~r_bus_p[c_CE];

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_push     <= 1'b0;
            r_push_rec <= '0;
        end else begin
            r_push     <= w_wr_evt | w_rd_evt;
            r_push_rec <= {~w_wr_evt, r_bus_p[c_A0], r_bus_p[DW-1:0]};
        end
    end

    // ------------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------------
    logic [c_RW-1:0]    r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_lvl;
    logic               r_ovf;
    logic               r_en_d;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;
    logic [c_RW-1:0]    w_head;

    assign w_full    = (r_lvl == c_FULL);
    assign w_empty   = (r_lvl == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = r_push & (~w_full | w_pop);
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_lvl  <= '0;
            r_ovf  <= 1'b0;
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= en;
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_lvl <= r_lvl + 1'b1;
                2'b01:   r_lvl <= r_lvl - 1'b1;
                default: r_lvl <= r_lvl;
            endcase
            // A drop is reported even if en falls in the same cycle.
            if (r_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (r_en_d && !en) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Serial transmitter
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [c_BCW-1:0]   r_baud;
    logic [c_BITW-1:0]  r_bit;
    logic [c_RW-1:0]    r_shift;
    logic               r_sout;
    logic               w_sout_nxt;
    logic               w_baud_done;

    assign w_baud_done = (r_baud == '0);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_sout_nxt  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_sout_nxt = 1'b0;
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_sout_nxt = r_shift[0];
                if (w_baud_done && (r_bit == c_LAST_BIT)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Every state change happens on a baud expiry or out of IDLE, so
    // reloading there covers each state entry and each data bit boundary.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_baud  <= c_BAUD_LAST;
            r_bit   <= '0;
            r_shift <= '0;
            r_sout  <= 1'b1;
        end else begin
            r_sout <= w_sout_nxt;
            if ((r_state == S_IDLE) || w_baud_done) begin
                r_baud <= c_BAUD_LAST;
            end else begin
                r_baud <= r_baud - 1'b1;
            end
            if (r_state != S_DATA) begin
                r_bit <= '0;
            end else if (w_baud_done) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_pop) begin
                r_shift <= w_head;
            end else if ((r_state == S_DATA) && w_baud_done) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    assign sout     = r_sout;
    assign busy     = (r_state != S_IDLE);
    assign ovf      = r_ovf;
    assign fifo_lvl = r_lvl;

endmodule
`default_nettype wire

// File: tb/tb_host_bus_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_host_bus_monitor
// Purpose  : Directed bench for host_bus_monitor (DW=8, FIFO_AW=2,
//            BAUD_DIV=4, SYNC_STG=2). A second instance with read capture
//            disabled shares all inputs. Frame timing is computed from the
//            cycle a strobe is released: record lands 4 clk later, is popped
//            1 clk after that, and frames repeat every 49 clk.
// Revision : 1.0  initial release
// ============================================================================
module tb_host_bus_monitor;

    localparam int DW = 8;

    logic        clk   = 1'b0;
    logic        rst_x = 1'b0;
    logic        ce_x  = 1'b1;
    logic        a0    = 1'b0;
    logic        wr_x  = 1'b1;
    logic        rd_x  = 1'b1;
    logic        en    = 1'b1;
    logic [7:0]  dat   = 8'h00;

    logic        sout, busy, ovf;
    logic [2:0]  fifo_lvl;
    logic        sout_nr, busy_nr, ovf_nr;
    logic [2:0]  lvl_nr;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    host_bus_monitor #(.DW(DW), .FIFO_AW(2), .BAUD_DIV(4), .CAP_RD(1), .SYNC_STG(2)) u_dut (
        .clk(clk), .rst_x(rst_x), .ce_x(ce_x), .a0(a0), .wr_x(wr_x), .rd_x(rd_x),
        .dat(dat), .en(en), .sout(sout), .busy(busy), .ovf(ovf), .fifo_lvl(fifo_lvl)
    );

    host_bus_monitor #(.DW(DW), .FIFO_AW(2), .BAUD_DIV(4), .CAP_RD(0), .SYNC_STG(2)) u_dut_nr (
        .clk(clk), .rst_x(rst_x), .ce_x(ce_x), .a0(a0), .wr_x(wr_x), .rd_x(rd_x),
        .dat(dat), .en(en), .sout(sout_nr), .busy(busy_nr), .ovf(ovf_nr), .fifo_lvl(lvl_nr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Advance to the negedge whose preceding posedge count equals t.
    task automatic wait_until(input int t);
        if (cyc > t) check_eq("late", cyc, t);
        while (cyc < t) @(negedge clk);
    endtask

    // One host access, started on a negedge. Data and a0 are scrambled at
    // strobe release so only the last low sample can be captured.
    task automatic host_acc(input logic is_rd, input logic a, input logic [7:0] d,
                            output int land);
        ce_x = 1'b0;
        a0   = a;
        dat  = d;
        if (is_rd) rd_x = 1'b0;
        else       wr_x = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_x = 1'b1;
        rd_x = 1'b1;
        ce_x = 1'b1;
        a0   = ~a;
        dat  = ~d;
        land = cyc + 4;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Check one frame whose pop happens on posedge 'pop'.
    task automatic chk_frame(input string tag, input int pop, input logic rd,
                             input logic a, input logic [7:0] d);
        logic [11:0] f;
        f = {1'b1, rd, a, d, 1'b0};
        wait_until(pop);
        check_eq({tag, "_pre_sout"}, sout, 1'b1);
        check_eq({tag, "_pre_busy"}, busy, 1'b1);
        for (int k = 0; k < 12; k++) begin
            wait_until(pop + 2 + 4 * k);
            check_eq($sformatf("%s_bit%0d", tag, k), sout, f[k]);
        end
        wait_until(pop + 47);
        check_eq({tag, "_busy_end"}, busy, 1'b1);
        wait_until(pop + 48);
        check_eq({tag, "_busy_gap"}, busy, 1'b0);
    endtask

    initial begin
        int land;
        int c0;

        // ---------------- reset ----------------
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_sout", sout, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_lvl", fifo_lvl, 3'd0);
        rst_x = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("post_rst_lvl", fifo_lvl, 3'd0);
        check_eq("post_rst_busy", busy, 1'b0);

        // ---------------- single write a0=1, 0xA5 ----------------
        host_acc(1'b0, 1'b1, 8'hA5, land);
        wait_until(land - 1);
        check_eq("t1_lvl_before", fifo_lvl, 3'd0);
        wait_until(land);
        check_eq("t1_lvl_land", fifo_lvl, 3'd1);
        check_eq("t1_busy_land", busy, 1'b0);
        chk_frame("t1", land + 1, 1'b0, 1'b1, 8'hA5);
        check_eq("t1_lvl_after", fifo_lvl, 3'd0);

        // ---------------- read a0=0, 0x3C ----------------
        repeat (3) @(negedge clk);
        host_acc(1'b1, 1'b0, 8'h3C, land);
        wait_until(land);
        check_eq("t2_lvl_land", fifo_lvl, 3'd1);
        check_eq("t2_nr_lvl_land", lvl_nr, 3'd0);
        wait_until(land + 1);
        check_eq("t2_nr_busy", busy_nr, 1'b0);
        chk_frame("t2", land + 1, 1'b1, 1'b0, 8'h3C);
        check_eq("t2_nr_lvl_end", lvl_nr, 3'd0);
        check_eq("t2_nr_sout", sout_nr, 1'b1);

        // ---------------- six writes, overflow ----------------
        repeat (3) @(negedge clk);
        c0 = cyc;
        fork
            begin : t3_wr
                int l3;
                for (int k = 1; k <= 6; k++) host_acc(1'b0, 1'b0, 8'(k), l3);
            end
            begin : t3_lvl
                wait_until(c0 + 25);
                check_eq("t3_lvl_full", fifo_lvl, 3'd4);
                check_eq("t3_ovf_before", ovf, 1'b0);
                wait_until(c0 + 26);
                check_eq("t3_lvl_drop", fifo_lvl, 3'd4);
                check_eq("t3_ovf_set", ovf, 1'b1);
            end
            begin : t3_frm
                for (int n = 0; n < 5; n++)
                    chk_frame($sformatf("t3_f%0d", n), c0 + 7 + 49 * n, 1'b0, 1'b0, 8'(n + 1));
            end
        join
        wait_until(c0 + 7 + 49 * 5 + 10);
        check_eq("t3_no6_busy", busy, 1'b0);
        check_eq("t3_no6_lvl", fifo_lvl, 3'd0);
        check_eq("t3_ovf_sticky", ovf, 1'b1);

        // ---------------- en dropped mid-frame ----------------
        c0 = cyc;
        fork
            begin : t6_ctl
                int l6;
                host_acc(1'b0, 1'b1, 8'h11, l6);
                host_acc(1'b0, 1'b0, 8'h22, l6);
                host_acc(1'b0, 1'b1, 8'h33, l6);
                wait_until(c0 + 30);
                check_eq("t6_ovf_held", ovf, 1'b1);
                en = 1'b0;
                @(negedge clk);
                check_eq("t6_ovf_clr", ovf, 1'b0);
                check_eq("t6_lvl_q", fifo_lvl, 3'd2);
                host_acc(1'b0, 1'b0, 8'h77, l6);
                wait_until(c0 + 40);
                check_eq("t6_lvl_noncap", fifo_lvl, 3'd2);
            end
            begin : t6_frm
                chk_frame("t6_f0", c0 + 7,   1'b0, 1'b1, 8'h11);
                chk_frame("t6_f1", c0 + 56,  1'b0, 1'b0, 8'h22);
                chk_frame("t6_f2", c0 + 105, 1'b0, 1'b1, 8'h33);
            end
        join
        wait_until(c0 + 170);
        check_eq("t6_drained_busy", busy, 1'b0);
        check_eq("t6_drained_lvl", fifo_lvl, 3'd0);
        check_eq("t6_drained_sout", sout, 1'b1);
        en = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- push coincident with pop while full ----------------
        c0 = cyc;
        fork
            begin : t4_wr
                int l4;
                for (int k = 0; k < 5; k++) host_acc(1'b0, 1'b0, 8'(8'h41 + k), l4);
                wait_until(c0 + 50);
                host_acc(1'b0, 1'b1, 8'h46, l4);
            end
            begin : t4_lvl
                wait_until(c0 + 55);
                check_eq("t4_lvl_idle", fifo_lvl, 3'd4);
                check_eq("t4_busy_idle", busy, 1'b0);
                wait_until(c0 + 56);
                check_eq("t4_lvl_pp", fifo_lvl, 3'd4);
                check_eq("t4_ovf_pp", ovf, 1'b0);
            end
            begin : t4_frm
                for (int n = 0; n < 6; n++)
                    chk_frame($sformatf("t4_f%0d", n), c0 + 7 + 49 * n, 1'b0,
                              (n == 5), 8'(8'h41 + n));
            end
        join
        check_eq("t4_ovf_end", ovf, 1'b0);
        check_eq("t4_lvl_end", fifo_lvl, 3'd0);

        // ---------------- reset during data bit 3 ----------------
        repeat (3) @(negedge clk);
        c0 = cyc;
        host_acc(1'b0, 1'b1, 8'hA5, land);
        host_acc(1'b0, 1'b0, 8'h66, land);
        wait_until(c0 + 25);
        check_eq("t5_sout_bit3", sout, 1'b0);
        check_eq("t5_busy_pre", busy, 1'b1);
        check_eq("t5_lvl_pre", fifo_lvl, 3'd1);
        rst_x = 1'b0;
        #1;
        check_eq("t5_sout_rst", sout, 1'b1);
        check_eq("t5_busy_rst", busy, 1'b0);
        check_eq("t5_lvl_rst", fifo_lvl, 3'd0);
        @(negedge clk);
        rst_x = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t5_busy_after", busy, 1'b0);
        host_acc(1'b0, 1'b1, 8'h3C, land);
        wait_until(land);
        check_eq("t5_lvl_land", fifo_lvl, 3'd1);
        chk_frame("t5_post", land + 1, 1'b0, 1'b1, 8'h3C);
        check_eq("t5_lvl_end", fifo_lvl, 3'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
